// File: rtl/mc_pkg.sv
// Shared types and helpers for the multi-cycle PC sequencer.
package mc_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_SEQ = 2'd0,
        KIND_BR  = 2'd1,
        KIND_J   = 2'd2,
        KIND_JR  = 2'd3
    } kind_e;

    // Sign-extended branch immediate, scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mc_pc_sequencer_if.sv
// Bus bundle between the PC sequencer and imem / decoder / execute stage.
interface mc_pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        dec_valid;
    logic [1:0]  dec_kind;
    logic        ex_done;
    logic        br_taken;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic        misalign;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err, misalign,
        input  imem_ready, imem_rdata, dec_valid, dec_kind, ex_done, br_taken, rs_val
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err, misalign,
        output imem_ready, imem_rdata, dec_valid, dec_kind, ex_done, br_taken, rs_val
    );
endinterface

// File: rtl/mc_next_pc.sv
// Next-PC selection: sequential, branch, pseudo-direct jump, register jump.
module mc_next_pc
    import mc_pkg::*;
(
    input  kind_e       kind,
    input  logic        br_taken,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic [31:0] rs_val,
    output logic [31:0] next_pc,
    output logic        misalign
);

    // Pick the target for the latched instruction class.
    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        case (kind)
            KIND_SEQ: next_pc = pc_plus4;
            KIND_BR: begin
                if (br_taken) begin
                    next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
                end else begin
                    next_pc = pc_plus4;
                end
            end
            // Region bits come from pc_plus4 so a jump in the last slot lands in the next region.
            KIND_J:   next_pc = {pc_plus4[31:28], instr_low, 2'b00};
            KIND_JR: begin
                next_pc  = {rs_val[31:2], 2'b00};
                misalign = (rs_val[1:0] != 2'b00);
            end
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/mc_pc_sequencer.sv
// Multi-cycle PC controller: owns the PC and sequences fetch, decode, execute.
module mc_pc_sequencer
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_pc_sequencer_if.master  bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_r;
    state_e            state_next_s;
    kind_e             kind_r;
    logic [31:0]       pc_r;
    logic [31:0]       pc_plus4_r;
    logic [31:0]       instr_r;
    logic              instr_valid_r;
    logic              fetch_err_r;
    logic              misalign_r;
    logic              imem_req_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              fetch_hit_s;
    logic              fetch_timeout_s;
    logic              dec_hit_s;
    logic              exec_done_s;
    logic [31:0]       next_pc_s;
    logic              jr_misalign_s;

    assign fetch_hit_s     = (state_r == FETCH) && bus.imem_ready;
    assign fetch_timeout_s = (state_r == FETCH) && !bus.imem_ready && (cnt_r == CNT_LAST);
    assign dec_hit_s       = (state_r == DECODE) && bus.dec_valid;
    assign exec_done_s     = (state_r == EXEC) && bus.ex_done;

    mc_next_pc u_next_pc (
        .kind      (kind_r),
        .br_taken  (bus.br_taken),
        .pc_plus4  (pc_plus4_r),
        .instr_low (instr_r[25:0]),
        .rs_val    (bus.rs_val),
        .next_pc   (next_pc_s),
        .misalign  (jr_misalign_s)
    );

    // Next-state logic: each phase waits for its own handshake only.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (bus.imem_ready) state_next_s = DECODE;
                else                state_next_s = FETCH;
            end
            DECODE: begin
                if (bus.dec_valid) state_next_s = EXEC;
                else               state_next_s = DECODE;
            end
            EXEC: begin
                if (bus.ex_done) state_next_s = FETCH;
                else             state_next_s = EXEC;
            end
            default: state_next_s = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= FETCH;
        else        state_r <= state_next_s;
    end

    // Fetch-wait counter; cleared on a hit, on timeout and outside FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if ((state_r == FETCH) && !bus.imem_ready && !fetch_timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Instruction, PC, link value and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            pc_plus4_r    <= RESET_PC + 32'd4;
            instr_r       <= 32'd0;
            kind_r        <= KIND_SEQ;
            instr_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
            misalign_r    <= 1'b0;
            imem_req_r    <= 1'b1;
        end else begin
            instr_valid_r <= fetch_hit_s;
            fetch_err_r   <= fetch_timeout_s;
            imem_req_r    <= (state_next_s == FETCH);
            if (fetch_hit_s) begin
                instr_r    <= bus.imem_rdata;
                pc_plus4_r <= pc_r + 32'd4;
            end
            if (dec_hit_s) begin
                kind_r <= kind_e'(bus.dec_kind);
            end
            if (exec_done_s) begin
                pc_r <= next_pc_s;
                if (jr_misalign_s) misalign_r <= 1'b1;
            end
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.pc          = pc_r;
    assign bus.pc_plus4    = pc_plus4_r;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.fetch_err   = fetch_err_r;
    assign bus.misalign    = misalign_r;

endmodule

// File: tb/tb_mc_pc_sequencer.sv
// Directed self-checking bench for mc_pc_sequencer.
module tb_mc_pc_sequencer;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    mc_pc_sequencer_if bus ();

    mc_pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Expected architectural view of the outputs.
    logic [31:0] exp_pc, exp_pc4, exp_instr;
    logic        exp_iv, exp_ferr, exp_mis, exp_req;
    logic [1:0]  cur_kind;
    int          stall_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Target address from the instruction class rules, plain arithmetic.
    function automatic logic [31:0] target(input logic [1:0] k, input logic [31:0] pc4,
                                           input logic [31:0] w, input logic br,
                                           input logic [31:0] rs);
        int off;
        off = int'($signed(w[15:0]));
        case (k)
            2'd1:    return br ? (pc4 + 32'(off * 4)) : pc4;
            2'd2:    return (pc4 & 32'hF000_0000) + ({6'd0, w[25:0]} * 32'd4);
            2'd3:    return rs & 32'hFFFF_FFFC;
            default: return pc4;
        endcase
    endfunction

    task automatic model_reset();
        exp_pc    = 32'h0000_0000;
        exp_pc4   = 32'h0000_0004;
        exp_instr = 32'h0000_0000;
        exp_iv    = 1'b0;
        exp_ferr  = 1'b0;
        exp_mis   = 1'b0;
        exp_req   = 1'b1;
        stall_cnt = 0;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",          bus.pc,                exp_pc);
            check("imem_addr",   bus.imem_addr,         exp_pc);
            check("pc_plus4",    bus.pc_plus4,          exp_pc4);
            check("instr",       bus.instr,             exp_instr);
            check("instr_valid", 32'(bus.instr_valid),  32'(exp_iv));
            check("imem_req",    32'(bus.imem_req),     32'(exp_req));
            check("fetch_err",   32'(bus.fetch_err),    32'(exp_ferr));
            check("misalign",    32'(bus.misalign),     32'(exp_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_iv   = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Stall for 'stall' cycles (decode/execute strobes are noise here), then deliver word.
    task automatic fetch_step(input logic [31:0] word, input int stall);
        for (int i = 0; i < stall; i++) begin
            bus.imem_ready = 1'b0;
            bus.dec_valid  = 1'b1;
            bus.ex_done    = 1'b1;
            tick();
            stall_cnt++;
            if (stall_cnt == TO) begin
                exp_ferr  = 1'b1;
                stall_cnt = 0;
            end
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        tick();
        exp_instr = word;
        exp_pc4   = exp_pc + 32'd4;
        exp_iv    = 1'b1;
        exp_req   = 1'b0;
        stall_cnt = 0;
        bus.imem_ready = 1'b0;
        bus.dec_valid  = 1'b0;
        bus.ex_done    = 1'b0;
    endtask

    task automatic decode_step(input logic [1:0] kind, input int wait_c);
        for (int i = 0; i < wait_c; i++) begin
            bus.dec_valid  = 1'b0;
            bus.imem_ready = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            bus.ex_done    = 1'b1;
            tick();
        end
        bus.dec_valid  = 1'b1;
        bus.dec_kind   = kind;
        bus.imem_ready = 1'b0;
        bus.ex_done    = 1'b0;
        tick();
        cur_kind      = kind;
        bus.dec_valid = 1'b0;
        bus.dec_kind  = ~kind;
    endtask

    task automatic exec_step(input logic br, input logic [31:0] rs, input int wait_c);
        for (int i = 0; i < wait_c; i++) begin
            bus.ex_done    = 1'b0;
            bus.dec_valid  = 1'b1;
            bus.imem_ready = 1'b1;
            bus.br_taken   = ~br;
            bus.rs_val     = 32'h1234_5677;
            tick();
        end
        bus.ex_done    = 1'b1;
        bus.dec_valid  = 1'b0;
        bus.imem_ready = 1'b1;
        bus.br_taken   = br;
        bus.rs_val     = rs;
        tick();
        exp_pc  = target(cur_kind, exp_pc4, exp_instr, br, rs);
        if ((cur_kind == 2'd3) && ((rs & 32'd3) != 32'd0)) exp_mis = 1'b1;
        exp_req = 1'b1;
        bus.ex_done    = 1'b0;
        bus.imem_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] word, input int fs, input int dw, input int ew,
                             input logic [1:0] kind, input logic br, input logic [31:0] rs);
        fetch_step(word, fs);
        decode_step(kind, dw);
        exec_step(br, rs, ew);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dec_valid  = 1'b0;
        bus.dec_kind   = 2'd0;
        bus.ex_done    = 1'b0;
        bus.br_taken   = 1'b0;
        bus.rs_val     = 32'h0;
        cur_kind       = 2'd0;
        model_reset();
        chk_en = 1'b1;
        tick();
        check("lit_reset_pc",  bus.pc, 32'h0000_0000);
        check("lit_reset_req", 32'(bus.imem_req), 32'd1);
        tick();
        rst_n = 1'b1;

        // Sequential instruction: 3-cycle minimum latency.
        run_instr(32'h2000_0001, 0, 0, 0, 2'd0, 1'b0, 32'h0);
        check("lit_seq_pc", bus.pc, 32'h0000_0004);

        // Branch taken backwards / not taken from 0x100.
        run_instr(32'h0000_0000, 1, 1, 1, 2'd3, 1'b0, 32'h0000_0100);
        run_instr(32'h1000_FFFE, 0, 0, 0, 2'd1, 1'b1, 32'h0);
        check("lit_br_taken", bus.pc, 32'h0000_00FC);
        run_instr(32'h0000_0000, 0, 0, 0, 2'd3, 1'b0, 32'h0000_0100);
        run_instr(32'h1000_FFFE, 0, 2, 0, 2'd1, 1'b0, 32'h0);
        check("lit_br_not_taken", bus.pc, 32'h0000_0104);

        // Pseudo-direct jump crossing into the next region.
        run_instr(32'h0000_0000, 0, 0, 0, 2'd3, 1'b0, 32'h0FFF_FFFC);
        run_instr(32'h0800_0010, 0, 0, 0, 2'd2, 1'b0, 32'h0);
        check("lit_jump", bus.pc, 32'h1000_0040);

        // Fetch timeouts, then normal progress.
        run_instr(32'h0000_0000, TO, 0, 0, 2'd0, 1'b0, 32'h0);
        check("lit_timeout_pc", bus.pc, 32'h1000_0044);
        run_instr(32'h0000_0000, 2 * TO + 1, 1, 3, 2'd0, 1'b0, 32'h0);
        check("lit_timeout2_pc", bus.pc, 32'h1000_0048);

        // Misaligned register jump; flag is sticky.
        run_instr(32'h0000_0000, 0, 0, 0, 2'd3, 1'b0, 32'h0000_2003);
        check("lit_jr_pc", bus.pc, 32'h0000_2000);
        check("lit_jr_mis", 32'(bus.misalign), 32'd1);
        run_instr(32'h0000_0000, 0, 0, 0, 2'd0, 1'b0, 32'h0);
        check("lit_mis_sticky", 32'(bus.misalign), 32'd1);

        // Reset while EXEC sees ex_done: the aborted instruction never updates pc.
        fetch_step(32'h0000_0000, 0);
        decode_step(2'd0, 0);
        bus.ex_done = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("lit_abort_pc",  bus.pc, 32'h0000_0000);
        check("lit_abort_mis", 32'(bus.misalign), 32'd0);
        tick();
        rst_n       = 1'b1;
        bus.ex_done = 1'b0;

        // Negative branch wraps below zero, sequential wraps back to zero.
        run_instr(32'h1000_FFFE, 0, 0, 0, 2'd1, 1'b1, 32'h0);
        check("lit_wrap_br", bus.pc, 32'hFFFF_FFFC);
        fetch_step(32'h0000_0000, 0);
        check("lit_wrap_pc4", bus.pc_plus4, 32'h0000_0000);
        decode_step(2'd0, 0);
        exec_step(1'b0, 32'h0, 0);
        check("lit_wrap_seq", bus.pc, 32'h0000_0000);

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
